// File: rtl/vga_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_core
// Description : VGA frame-buffer controller. Generates 640x480@60 timing,
//               fetches 320x240x8 pixels from an asynchronous SRAM (each
//               pixel doubled in both directions), and accepts MPU writes
//               through a small register file. Video and MPU share the SRAM
//               on alternating clocks (even hCount = video, odd = MPU).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_core #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int FB_WIDTH  = 320
) (
   input  logic        clock,
   input  logic        resetN,
   output logic        hSync,
   output logic        vSync,
   output logic [7:0]  videoOutputData,
   output logic [16:0] ramAddress,
   inout  wire  [7:0]  ramData,
   output logic        ramWriteEnable,
   output logic        ramOutputEnable,
   input  logic        mpuChipSelect,
   input  logic        mpuWriteEnable,
   input  logic [2:0]  mpuRegisterSelect,
   inout  wire  [7:0]  mpuDataBus
);

   localparam int C_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int C_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int C_HW      = $clog2(C_H_TOTAL);
   localparam int C_VW      = $clog2(C_V_TOTAL);

   localparam logic [C_HW-1:0] C_H_LAST   = C_HW'(C_H_TOTAL - 1);
   localparam logic [C_HW-1:0] C_H_VIS    = C_HW'(H_VISIBLE);
   localparam logic [C_HW-1:0] C_HS_START = C_HW'(H_VISIBLE + H_FRONT);
   localparam logic [C_HW-1:0] C_HS_END   = C_HW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [C_VW-1:0] C_V_LAST   = C_VW'(C_V_TOTAL - 1);
   localparam logic [C_VW-1:0] C_V_VIS    = C_VW'(V_VISIBLE);
   localparam logic [C_VW-1:0] C_VS_START = C_VW'(V_VISIBLE + V_FRONT);
   localparam logic [C_VW-1:0] C_VS_END   = C_VW'(V_VISIBLE + V_FRONT + V_SYNC);

   // timing counters and their one-clock-delayed copies
   logic [C_HW-1:0] h_count_q, h_count_d, h_dly_q, h_dly_d;
   logic [C_VW-1:0] v_count_q, v_count_d, v_dly_q, v_dly_d;
   // registered video outputs
   logic            hsync_q, hsync_d, vsync_q, vsync_d;
   logic [7:0]      video_q, video_d, pixel_q, pixel_d;
   // registered SRAM controls
   logic [16:0]     ram_addr_q, ram_addr_d;
   logic [7:0]      ram_wdata_q, ram_wdata_d;
   logic            ram_we_n_q, ram_we_n_d, ram_oe_n_q, ram_oe_n_d;
   // MPU synchronizers and register file
   logic            cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d;
   logic            we_meta_q, we_meta_d, we_sync_q, we_sync_d;
   logic            wr_prev_q, wr_prev_d;
   logic            wr_level, wr_strobe;
   logic [16:0]     addr_q, addr_d, pend_addr_q, pend_addr_d;
   logic [7:0]      pend_data_q, pend_data_d;
   logic            pending_q, pending_d;
   logic [16:0]     vid_addr;
   logic            vblank;
   logic [7:0]      rd_data;

   // Raster counters, two-stage output pipeline and pixel latch
   always_comb begin
      h_count_d = h_count_q + C_HW'(1);
      v_count_d = v_count_q;
      if (h_count_q == C_H_LAST) begin
         h_count_d = '0;
         v_count_d = (v_count_q == C_V_LAST) ? '0 : v_count_q + C_VW'(1);
      end
      h_dly_d = h_count_q;
      v_dly_d = v_count_q;
      hsync_d = !((h_dly_q >= C_HS_START) && (h_dly_q < C_HS_END));
      vsync_d = !((v_dly_q >= C_VS_START) && (v_dly_q < C_VS_END));
      video_d = ((h_dly_q < C_H_VIS) && (v_dly_q < C_V_VIS)) ? pixel_q : 8'h00;
      // the fetched byte serves both columns of a doubled pixel pair
      pixel_d = (!ram_oe_n_q) ? ramData : pixel_q;
   end

   // MPU strobe detection and register-file updates
   always_comb begin
      cs_meta_d   = mpuChipSelect;
      cs_sync_d   = cs_meta_q;
      we_meta_d   = mpuWriteEnable;
      we_sync_d   = we_meta_q;
      wr_level    = cs_sync_q & we_sync_q;
      wr_prev_d   = wr_level;
      wr_strobe   = wr_level & ~wr_prev_q;
      addr_d      = addr_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      // a write issued to the SRAM this cycle retires the pending slot
      pending_d   = pending_q & ram_we_n_q;
      if (wr_strobe) begin
         case (mpuRegisterSelect)
            3'd0: addr_d[7:0]  = mpuDataBus;
            3'd1: addr_d[15:8] = mpuDataBus;
            3'd2: addr_d[16]   = mpuDataBus[0];
            3'd3: begin
               pend_addr_d = addr_q;
               pend_data_d = mpuDataBus;
               pending_d   = 1'b1;
               addr_d      = addr_q + 17'd1;
            end
            default: ;
         endcase
      end
   end

   // Next-cycle SRAM slot: video fetch on even hCount, pending MPU write on odd
   always_comb begin
      vid_addr    = 17'(v_count_d >> 1) * 17'(FB_WIDTH) + 17'(h_count_d >> 1);
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_n_d  = 1'b1;
      ram_oe_n_d  = 1'b1;
      if (!h_count_d[0]) begin
         ram_addr_d = vid_addr;
         ram_oe_n_d = 1'b0;
      end else if (pending_d) begin
         ram_addr_d  = pend_addr_d;
         ram_wdata_d = pend_data_d;
         ram_we_n_d  = 1'b0;
      end
   end

   // MPU read-back mux
   always_comb begin
      vblank  = (v_count_q >= C_V_VIS);
      rd_data = 8'h00;
      case (mpuRegisterSelect)
         3'd0:    rd_data = addr_q[7:0];
         3'd1:    rd_data = addr_q[15:8];
         3'd2:    rd_data = {7'd0, addr_q[16]};
         3'd4:    rd_data = {6'd0, vblank, pending_q};
         default: rd_data = 8'h00;
      endcase
   end

   // All state, cleared asynchronously by resetN
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         h_count_q   <= '0;
         v_count_q   <= '0;
         h_dly_q     <= '0;
         v_dly_q     <= '0;
         hsync_q     <= 1'b1;
         vsync_q     <= 1'b1;
         video_q     <= 8'h00;
         pixel_q     <= 8'h00;
         ram_addr_q  <= '0;
         ram_wdata_q <= 8'h00;
         ram_we_n_q  <= 1'b1;
         ram_oe_n_q  <= 1'b1;
         cs_meta_q   <= 1'b0;
         cs_sync_q   <= 1'b0;
         we_meta_q   <= 1'b0;
         we_sync_q   <= 1'b0;
         wr_prev_q   <= 1'b0;
         addr_q      <= '0;
         pend_addr_q <= '0;
         pend_data_q <= 8'h00;
         pending_q   <= 1'b0;
      end else begin
         h_count_q   <= h_count_d;
         v_count_q   <= v_count_d;
         h_dly_q     <= h_dly_d;
         v_dly_q     <= v_dly_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         video_q     <= video_d;
         pixel_q     <= pixel_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_we_n_q  <= ram_we_n_d;
         ram_oe_n_q  <= ram_oe_n_d;
         cs_meta_q   <= cs_meta_d;
         cs_sync_q   <= cs_sync_d;
         we_meta_q   <= we_meta_d;
         we_sync_q   <= we_sync_d;
         wr_prev_q   <= wr_prev_d;
         addr_q      <= addr_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         pending_q   <= pending_d;
      end
   end

   assign hSync           = hsync_q;
   assign vSync           = vsync_q;
   assign videoOutputData = video_q;
   assign ramAddress      = ram_addr_q;
   assign ramWriteEnable  = ram_we_n_q;
   assign ramOutputEnable = ram_oe_n_q;
   assign ramData         = ram_we_n_q ? 8'bzzzz_zzzz : ram_wdata_q;
   assign mpuDataBus      = (mpuChipSelect && !mpuWriteEnable) ? rd_data : 8'bzzzz_zzzz;

endmodule
`default_nettype wire

// File: tb/tb_vga_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_core
// Description : Self-checking bench for vga_core. Horizontal timing is the
//               full 800-clock line; the frame is shortened to 15 lines
//               (8 visible) so whole frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_core;

   localparam int HT = 800;
   localparam int VV = 8;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int VT = VV + VF + VS + VB;

   typedef struct {
      logic [16:0] addr;
      logic [7:0]  data;
      int          deadline;
   } wr_t;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic        hSync, vSync, ramWriteEnable, ramOutputEnable;
   logic [7:0]  videoOutputData;
   logic [16:0] ramAddress;
   wire  [7:0]  ramData;
   wire  [7:0]  mpuDataBus;
   logic        mpuChipSelect = 1'b0;
   logic        mpuWriteEnable = 1'b0;
   logic [2:0]  mpuRegisterSelect = 3'd0;
   logic        tb_drive = 1'b0;
   logic [7:0]  tb_bus = 8'h00;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [16:0] model_addr = 17'd0;
   wr_t         wr_q[$];
   logic [7:0]  pix_q[$];
   wr_t         mon_e;

   vga_core #(
      .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .FB_WIDTH(320)
   ) dut (
      .clock(clock),
      .resetN(resetN),
      .hSync(hSync),
      .vSync(vSync),
      .videoOutputData(videoOutputData),
      .ramAddress(ramAddress),
      .ramData(ramData),
      .ramWriteEnable(ramWriteEnable),
      .ramOutputEnable(ramOutputEnable),
      .mpuChipSelect(mpuChipSelect),
      .mpuWriteEnable(mpuWriteEnable),
      .mpuRegisterSelect(mpuRegisterSelect),
      .mpuDataBus(mpuDataBus)
   );

   always #20 clock = ~clock;

   // SRAM model: reads return the low address byte
   assign ramData    = (!ramOutputEnable) ? ramAddress[7:0] : 8'bzzzz_zzzz;
   assign mpuDataBus = tb_drive ? tb_bus : 8'bzzzz_zzzz;

   // bench-side raster index: after n rising edges, hCount = n % HT
   always @(posedge clock or negedge resetN) begin
      if (!resetN) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   // SRAM write monitor: pops the expected write from the scoreboard
   always @(negedge clock) begin
      if (resetN && ramWriteEnable === 1'b0) begin
         n_cmp++;
         if (wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL sram_write_unexpected: addr=%h data=%h cyc=%0d", ramAddress, ramData, cyc);
         end else begin
            mon_e = wr_q.pop_front();
            if (ramAddress !== mon_e.addr || ramData !== mon_e.data || cyc > mon_e.deadline ||
                (cyc % 2) != 1 || ramOutputEnable !== 1'b1) begin
               n_fail++;
               $display("FAIL sram_write: got addr=%h data=%h cyc=%0d oe=%b, want addr=%h data=%h odd cyc<=%0d oe=1",
                        ramAddress, ramData, cyc, ramOutputEnable, mon_e.addr, mon_e.data, mon_e.deadline);
            end
         end
      end
   end

   function automatic logic [7:0] exp_pix(input int col, input int line);
      if (col < 640 && line < VV) return 8'(((line / 2) * 320 + col / 2) & 255);
      return 8'h00;
   endfunction

   function automatic logic model_vblank();
      return ((cyc / HT) % VT) >= VV;
   endfunction

   task automatic wait_hv(input int h, input int v);
      int n = 0;
      do begin
         @(posedge clock); #1;
         n++;
      end while (!((cyc % HT) == h && ((cyc / HT) % VT) == v) && n < 2 * HT * VT);
      if (!((cyc % HT) == h && ((cyc / HT) % VT) == v)) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_hv_timeout: got cyc=%0d, want h=%0d v=%0d", cyc, h, v);
      end
   endtask

   task automatic mpu_write(input logic [2:0] sel, input logic [7:0] d);
      wr_t e;
      @(posedge clock); #1;
      mpuRegisterSelect = sel;
      tb_bus = d; tb_drive = 1'b1;
      mpuChipSelect = 1'b1; mpuWriteEnable = 1'b1;
      case (sel)
         3'd0: model_addr[7:0]  = d;
         3'd1: model_addr[15:8] = d;
         3'd2: model_addr[16]   = d[0];
         3'd3: begin
            e.addr = model_addr; e.data = d; e.deadline = cyc + 4;
            wr_q.push_back(e);
            model_addr = model_addr + 17'd1;
         end
         default: ;
      endcase
      repeat (4) @(posedge clock);
      #1;
      mpuChipSelect = 1'b0; mpuWriteEnable = 1'b0; tb_drive = 1'b0;
      repeat (3) @(posedge clock);
   endtask

   task automatic mpu_read(input logic [2:0] sel, output logic [7:0] d);
      @(posedge clock); #1;
      mpuRegisterSelect = sel; mpuWriteEnable = 1'b0; mpuChipSelect = 1'b1;
      #1;
      d = mpuDataBus;
      mpuChipSelect = 1'b0;
   endtask

   task automatic check_read(input logic [2:0] sel, input logic [7:0] want, input string name);
      logic [7:0] got;
      mpu_read(sel, got);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic drain_writes();
      int n = 0;
      while (wr_q.size() != 0 && n < 20) begin
         @(posedge clock); n++;
      end
      n_cmp++;
      if (wr_q.size() != 0) begin
         n_fail++;
         $display("FAIL write_drain_timeout: %0d writes outstanding, want 0", wr_q.size());
         wr_q.delete();
      end
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if (hSync !== 1'b1 || vSync !== 1'b1 || ramWriteEnable !== 1'b1 || ramOutputEnable !== 1'b1 ||
          ramAddress !== 17'd0 || videoOutputData !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got hs=%b vs=%b we=%b oe=%b addr=%h vid=%h, want 1 1 1 1 0 0",
                  hSync, vSync, ramWriteEnable, ramOutputEnable, ramAddress, videoOutputData);
      end
      @(negedge clock);
      resetN = 1'b1;
      check_read(3'd4, 8'h00, "reset_status");
      check_read(3'd0, 8'h00, "reset_addr0");
   endtask

   task automatic test_hsync();
      int   lows = 0;
      int   first = -1;
      logic prev = 1'b1;
      wait_hv(0, 1);
      for (int i = 0; i < HT; i++) begin
         if (i > 0) begin @(posedge clock); #1; end
         if (hSync === 1'b0) begin
            lows++;
            if (prev === 1'b1 && first < 0) first = i;
         end
         prev = hSync;
      end
      n_cmp++;
      if (lows != 96) begin
         n_fail++; $display("FAIL hsync_width: got %0d, want 96", lows);
      end
      n_cmp++;
      if (first != 658) begin
         n_fail++; $display("FAIL hsync_fall: got %0d, want 658", first);
      end
   endtask

   task automatic test_vsync();
      int   vlows = 0;
      int   hlows = 0;
      int   first = -1;
      logic prev = 1'b1;
      wait_hv(0, 0);
      for (int i = 0; i < HT * VT; i++) begin
         if (i > 0) begin @(posedge clock); #1; end
         if (hSync === 1'b0) hlows++;
         if (vSync === 1'b0) begin
            vlows++;
            if (prev === 1'b1 && first < 0) first = i;
         end
         prev = vSync;
      end
      n_cmp++;
      if (vlows != VS * HT) begin
         n_fail++; $display("FAIL vsync_width: got %0d, want %0d", vlows, VS * HT);
      end
      n_cmp++;
      if (first != (VV + VF) * HT + 2) begin
         n_fail++; $display("FAIL vsync_fall: got %0d, want %0d", first, (VV + VF) * HT + 2);
      end
      n_cmp++;
      if (hlows != 96 * VT) begin
         n_fail++; $display("FAIL hsync_per_frame: got %0d, want %0d", hlows, 96 * VT);
      end
   endtask

   task automatic test_video();
      logic [16:0] exp_a;
      logic [7:0]  exp_p;
      wait_hv(0, 2);
      for (int i = 0; i < HT + 2; i++) begin
         if (i > 0) begin @(posedge clock); #1; end
         if (i < HT && (i % 2) == 0) begin
            exp_a = 17'((2 / 2) * 320 + i / 2);
            n_cmp++;
            if (ramAddress !== exp_a || ramOutputEnable !== 1'b0 || ramWriteEnable !== 1'b1) begin
               n_fail++;
               $display("FAIL fetch_slot h=%0d: got addr=%h oe=%b we=%b, want addr=%h oe=0 we=1",
                        i, ramAddress, ramOutputEnable, ramWriteEnable, exp_a);
            end
            pix_q.push_back(exp_pix(i, 2));
            pix_q.push_back(exp_pix(i + 1, 2));
         end
         if (i == 4) begin
            n_cmp++;
            if (ramAddress !== 17'd322) begin
               n_fail++; $display("FAIL fetch_addr_322: got %0d, want 322", ramAddress);
            end
         end
         if (i >= 2) begin
            exp_p = pix_q.pop_front();
            n_cmp++;
            if (videoOutputData !== exp_p) begin
               n_fail++;
               $display("FAIL pixel col=%0d: got %h, want %h", i - 2, videoOutputData, exp_p);
            end
         end
         if (i == 6 || i == 7) begin
            n_cmp++;
            if (videoOutputData !== 8'h42) begin
               n_fail++; $display("FAIL pixel_42 col=%0d: got %h, want 42", i - 2, videoOutputData);
            end
         end
      end
      // vertical blanking line: pixels 0 although fetches continue
      wait_hv(0, VV + 1);
      for (int i = 0; i < 100; i++) begin
         if (i > 0) begin @(posedge clock); #1; end
         n_cmp++;
         if (videoOutputData !== 8'h00 || ((i % 2) == 0 && ramOutputEnable !== 1'b0)) begin
            n_fail++;
            $display("FAIL vblank_pixel i=%0d: got vid=%h oe=%b, want vid=00 oe=%b",
                     i, videoOutputData, ramOutputEnable, (i % 2) != 0);
         end
      end
   endtask

   task automatic test_mpu_write();
      mpu_write(3'd0, 8'h34);
      mpu_write(3'd1, 8'h12);
      mpu_write(3'd2, 8'h01);
      mpu_write(3'd3, 8'hA5);
      drain_writes();
      check_read(3'd0, 8'h35, "addr_lo_after_write");
      check_read(3'd1, 8'h12, "addr_mid_after_write");
      check_read(3'd2, 8'h01, "addr_hi_after_write");
      check_read(3'd3, 8'h00, "data_reg_read");
      check_read(3'd5, 8'h00, "reg5_read");
   endtask

   task automatic test_back_to_back();
      mpu_write(3'd0, 8'hFF);
      mpu_write(3'd1, 8'hFF);
      mpu_write(3'd2, 8'hFF);
      check_read(3'd2, 8'h01, "addr_hi_bit_only");
      mpu_write(3'd3, 8'h11);
      mpu_write(3'd3, 8'h22);
      drain_writes();
      check_read(3'd0, 8'h01, "addr_lo_wrapped");
      check_read(3'd1, 8'h00, "addr_mid_wrapped");
      check_read(3'd2, 8'h00, "addr_hi_wrapped");
   endtask

   task automatic test_status();
      wr_t        e;
      logic [7:0] got;
      logic [7:0] want;
      wait_hv(0, VV + 1);
      check_read(3'd4, 8'h02, "status_vblank");
      // data write, then read status as soon as the strobe has been taken
      @(posedge clock); #1;
      mpuRegisterSelect = 3'd3; tb_bus = 8'h5A; tb_drive = 1'b1;
      mpuChipSelect = 1'b1; mpuWriteEnable = 1'b1;
      e.addr = model_addr; e.data = 8'h5A; e.deadline = cyc + 4;
      wr_q.push_back(e);
      model_addr = model_addr + 17'd1;
      repeat (3) @(posedge clock);
      #1;
      tb_drive = 1'b0; mpuWriteEnable = 1'b0; mpuRegisterSelect = 3'd4;
      #1;
      got  = mpuDataBus;
      want = {6'd0, model_vblank(), 1'b1};
      n_cmp++;
      if (got !== want) begin
         n_fail++; $display("FAIL status_pending_set: got %h, want %h", got, want);
      end
      repeat (2) @(posedge clock);
      #1;
      got  = mpuDataBus;
      want = {6'd0, model_vblank(), 1'b0};
      n_cmp++;
      if (got !== want) begin
         n_fail++; $display("FAIL status_pending_clear: got %h, want %h", got, want);
      end
      mpuChipSelect = 1'b0;
      repeat (3) @(posedge clock);
      drain_writes();
   endtask

   initial begin
      test_reset();
      test_hsync();
      test_vsync();
      test_video();
      test_mpu_write();
      test_back_to_back();
      test_status();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
